// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the seven-segment capture block.
//   - SEG7_0 .. SEG7_F : active-low glyph patterns, bit6 = a ... bit0 = g
//   - seg7_state_e     : capture FSM states (ACQ, CNT, LOCK)
package seg7_pkg;

  localparam logic [6:0] SEG7_0 = 7'b0000001;
  localparam logic [6:0] SEG7_1 = 7'b1001111;
  localparam logic [6:0] SEG7_2 = 7'b0010010;
  localparam logic [6:0] SEG7_3 = 7'b0000110;
  localparam logic [6:0] SEG7_4 = 7'b1001100;
  localparam logic [6:0] SEG7_5 = 7'b0100100;
  localparam logic [6:0] SEG7_6 = 7'b0100000;
  localparam logic [6:0] SEG7_7 = 7'b0001111;
  localparam logic [6:0] SEG7_8 = 7'b0000000;
  localparam logic [6:0] SEG7_9 = 7'b0000100;
  localparam logic [6:0] SEG7_A = 7'b0001000;
  localparam logic [6:0] SEG7_B = 7'b1100000;
  localparam logic [6:0] SEG7_C = 7'b0110001;
  localparam logic [6:0] SEG7_D = 7'b1000010;
  localparam logic [6:0] SEG7_E = 7'b0110000;
  localparam logic [6:0] SEG7_F = 7'b0111000;

  typedef enum logic [1:0] {
    ACQ  = 2'd0,
    CNT  = 2'd1,
    LOCK = 2'd2
  } seg7_state_e;

endpackage

// File: rtl/seg7_capture_if.sv
// seg7_capture_if: sample/result bundle of the seven-segment capture block.
//   sample_en          : sample strobe
//   seg_lsd / seg_msd  : active-low segment patterns of the low / high digit
//   value              : last locked value {msd nibble, lsd nibble}
//   locked             : capture FSM is in LOCK
//   new_valid          : one-cycle pulse on every entry into LOCK
//   err                : one-cycle pulse after a strobe with an invalid glyph
//   err_count          : saturating count of invalid strobes (0 when not built)
// Modports: master drives the samples and observes results, slave is the capture block.
interface seg7_capture_if;
  logic       sample_en;
  logic [6:0] seg_lsd;
  logic [6:0] seg_msd;
  logic [7:0] value;
  logic       locked;
  logic       new_valid;
  logic       err;
  logic [7:0] err_count;

  modport master (
    output sample_en, seg_lsd, seg_msd,
    input  value, locked, new_valid, err, err_count
  );

  modport slave (
    input  sample_en, seg_lsd, seg_msd,
    output value, locked, new_valid, err, err_count
  );
endinterface

// File: rtl/seg7_digit_dec.sv
// seg7_digit_dec: combinational decode of one active-low 7-segment pattern
// back into its hex nibble.
//   seg_i : pattern, bit6 = a ... bit0 = g
//   nib_o : decoded nibble (4'h0 when the pattern is not a known glyph)
//   ok_o  : 1 when seg_i matches one of the 16 glyphs
module seg7_digit_dec
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] nib_o,
  output logic       ok_o
);

  // Pattern-to-nibble lookup; anything off the glyph table is invalid.
  always_comb begin
    nib_o = 4'h0;
    ok_o  = 1'b1;
    case (seg_i)
      SEG7_0:  nib_o = 4'h0;
      SEG7_1:  nib_o = 4'h1;
      SEG7_2:  nib_o = 4'h2;
      SEG7_3:  nib_o = 4'h3;
      SEG7_4:  nib_o = 4'h4;
      SEG7_5:  nib_o = 4'h5;
      SEG7_6:  nib_o = 4'h6;
      SEG7_7:  nib_o = 4'h7;
      SEG7_8:  nib_o = 4'h8;
      SEG7_9:  nib_o = 4'h9;
      SEG7_A:  nib_o = 4'hA;
      SEG7_B:  nib_o = 4'hB;
      SEG7_C:  nib_o = 4'hC;
      SEG7_D:  nib_o = 4'hD;
      SEG7_E:  nib_o = 4'hE;
      SEG7_F:  nib_o = 4'hF;
      default: begin
        nib_o = 4'h0;
        ok_o  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seg7_capture.sv
// seg7_capture: reads a two-digit active-low 7-segment display back into an
// 8-bit value. A value is published only after STABLE_CNT consecutive identical
// valid strobes; strobes carrying an invalid glyph are flagged.
// Parameters:
//   STABLE_CNT : matching strobes required to lock (1..255), default 4
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : seg7_capture_if.slave (samples in, value/locked/new_valid/err/err_count out)
// Build option:
//   SEG7_CAPTURE_ERRCNT_EN : when defined, builds the saturating error counter;
//                            otherwise err_count is tied to 8'h00.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CNT = 4
)(
  input  logic           clk,
  input  logic           rst_n,
  seg7_capture_if.slave  bus
);

  localparam logic [7:0] STABLE_LIM = 8'(STABLE_CNT);

  logic [3:0]  lsd_nib;
  logic [3:0]  msd_nib;
  logic        lsd_ok;
  logic        msd_ok;
  logic [7:0]  cand;
  logic        ok;
  logic [7:0]  cnt_inc;

  seg7_state_e state_q, state_d;
  logic [7:0]  hold_q, hold_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  value_q, value_d;
  logic        locked_q, locked_d;
  logic        new_valid_q, new_valid_d;
  logic        err_q, err_d;

  seg7_digit_dec u_dec_lsd (
    .seg_i (bus.seg_lsd),
    .nib_o (lsd_nib),
    .ok_o  (lsd_ok)
  );

  seg7_digit_dec u_dec_msd (
    .seg_i (bus.seg_msd),
    .nib_o (msd_nib),
    .ok_o  (msd_ok)
  );

  assign cand    = {msd_nib, lsd_nib};
  assign ok      = lsd_ok & msd_ok;
  assign cnt_inc = cnt_q + 8'd1;

  // Capture FSM: an invalid strobe wins over everything, including a strobe
  // that would otherwise complete the count.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    cnt_d       = cnt_q;
    value_d     = value_q;
    new_valid_d = 1'b0;
    err_d       = 1'b0;
    if (bus.sample_en) begin
      if (!ok) begin
        state_d = ACQ;
        cnt_d   = 8'd0;
        err_d   = 1'b1;
      end else begin
        case (state_q)
          ACQ: begin
            hold_d = cand;
            cnt_d  = 8'd1;
            if (STABLE_LIM == 8'd1) begin
              state_d     = LOCK;
              value_d     = cand;
              new_valid_d = 1'b1;
            end else begin
              state_d = CNT;
            end
          end
          CNT: begin
            if (cand == hold_q) begin
              cnt_d = cnt_inc;
              if (cnt_inc == STABLE_LIM) begin
                state_d     = LOCK;
                value_d     = hold_q;
                new_valid_d = 1'b1;
              end else begin
                state_d = CNT;
              end
            end else begin
              // A different value restarts the count from this strobe.
              hold_d  = cand;
              cnt_d   = 8'd1;
              state_d = CNT;
            end
          end
          LOCK: begin
            if (cand == hold_q) begin
              state_d = LOCK;
            end else begin
              // value keeps the old lock until the new one completes.
              hold_d = cand;
              cnt_d  = 8'd1;
              if (STABLE_LIM == 8'd1) begin
                state_d     = LOCK;
                value_d     = cand;
                new_valid_d = 1'b1;
              end else begin
                state_d = CNT;
              end
            end
          end
          default: begin
            state_d = ACQ;
            cnt_d   = 8'd0;
          end
        endcase
      end
    end else begin
      state_d = state_q;
    end
    locked_d = (state_d == LOCK);
  end

  // FSM and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACQ;
      hold_q      <= 8'h00;
      cnt_q       <= 8'd0;
      value_q     <= 8'h00;
      locked_q    <= 1'b0;
      new_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      cnt_q       <= cnt_d;
      value_q     <= value_d;
      locked_q    <= locked_d;
      new_valid_q <= new_valid_d;
      err_q       <= err_d;
    end
  end

  assign bus.value     = value_q;
  assign bus.locked    = locked_q;
  assign bus.new_valid = new_valid_q;
  assign bus.err       = err_q;

`ifdef SEG7_CAPTURE_ERRCNT_EN
  logic [7:0] err_count_q, err_count_d;

  // Saturating error counter, advances on the same edge that raises err.
  always_comb begin
    if (err_d && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end else begin
      err_count_d = err_count_q;
    end
  end

  // Error counter register, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_q <= 8'h00;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign bus.err_count = err_count_q;
`else
  assign bus.err_count = 8'h00;
`endif

endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture: directed self-checking bench for seg7_capture.
// Instance a uses STABLE_CNT=4, instance b uses STABLE_CNT=1. Every expected
// lock is pushed to a per-instance queue when its final strobe is driven and
// popped when the instance pulses new_valid.
module tb_seg7_capture;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  seg7_capture_if if_a ();
  seg7_capture_if if_b ();

  seg7_capture #(.STABLE_CNT(4)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a.slave)
  );

  seg7_capture #(.STABLE_CNT(1)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b.slave)
  );

  int         n_pass = 0;
  int         n_chk  = 0;
  int         err_a  = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  function automatic logic [7:0] exp_errcnt(input int n);
`ifdef SEG7_CAPTURE_ERRCNT_EN
    return (n > 255) ? 8'hFF : 8'(n);
`else
    return (n > 0) ? 8'h00 : 8'h00;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Scoreboard: every new_valid pulse must match the oldest pending lock.
  task automatic observe();
    if (if_a.new_valid === 1'b1) begin
      chk("a_pulse_expected", 32'(q_a.size() != 0), 32'd1);
      if (q_a.size() != 0) chk("a_locked_value", 32'(if_a.value), 32'(q_a.pop_front()));
    end
    if (if_b.new_valid === 1'b1) begin
      chk("b_pulse_expected", 32'(q_b.size() != 0), 32'd1);
      if (q_b.size() != 0) chk("b_locked_value", 32'(if_b.value), 32'(q_b.pop_front()));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    observe();
  endtask

  task automatic raw_a(input logic en, input logic [6:0] msd, input logic [6:0] lsd);
    if_a.sample_en = en;
    if_a.seg_msd   = msd;
    if_a.seg_lsd   = lsd;
    tick();
  endtask

  task automatic strobe_a(input logic [7:0] v);
    raw_a(1'b1, glyph(v[7:4]), glyph(v[3:0]));
  endtask

  task automatic idle_a(input int n);
    for (int k = 0; k < n; k++) raw_a(1'b0, if_a.seg_msd, if_a.seg_lsd);
  endtask

  task automatic raw_b(input logic en, input logic [6:0] msd, input logic [6:0] lsd);
    if_b.sample_en = en;
    if_b.seg_msd   = msd;
    if_b.seg_lsd   = lsd;
    tick();
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_value"}, 32'(if_a.value), 32'h00);
    chk({tag, "_locked"}, 32'(if_a.locked), 32'd0);
    chk({tag, "_new_valid"}, 32'(if_a.new_valid), 32'd0);
    chk({tag, "_err"}, 32'(if_a.err), 32'd0);
    chk({tag, "_err_count"}, 32'(if_a.err_count), 32'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    if_a.sample_en = 1'b0; if_a.seg_msd = 7'h00; if_a.seg_lsd = 7'h00;
    if_b.sample_en = 1'b0; if_b.seg_msd = 7'h00; if_b.seg_lsd = 7'h00;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_a("rst_a");
    chk("rst_b_value", 32'(if_b.value), 32'h00);
    chk("rst_b_locked", 32'(if_b.locked), 32'd0);
    rst_n = 1'b1;

    // Lock and hold on 8'hAC.
    for (int i = 0; i < 4; i++) begin
      if (i == 3) q_a.push_back(8'hAC);
      strobe_a(8'hAC);
      chk("ac_locked", 32'(if_a.locked), 32'(i == 3));
      chk("ac_pulse", 32'(if_a.new_valid), 32'(i == 3));
    end
    chk("ac_value", 32'(if_a.value), 32'hAC);
    for (int i = 0; i < 3; i++) begin
      strobe_a(8'hAC);
      chk("ac_hold_locked", 32'(if_a.locked), 32'd1);
      chk("ac_hold_no_pulse", 32'(if_a.new_valid), 32'd0);
    end
    chk("ac_drained", 32'(q_a.size()), 32'd0);

    // Count restart: 12 x3, then 13 x4.
    for (int i = 0; i < 3; i++) begin
      strobe_a(8'h12);
      chk("r12_locked", 32'(if_a.locked), 32'd0);
      chk("r12_value_kept", 32'(if_a.value), 32'hAC);
    end
    for (int i = 0; i < 4; i++) begin
      if (i == 3) q_a.push_back(8'h13);
      strobe_a(8'h13);
      chk("r13_locked", 32'(if_a.locked), 32'(i == 3));
    end
    chk("r13_value", 32'(if_a.value), 32'h13);

    // Invalid glyph while locked at 8'h55.
    for (int i = 0; i < 4; i++) begin
      if (i == 3) q_a.push_back(8'h55);
      strobe_a(8'h55);
    end
    chk("l55_locked", 32'(if_a.locked), 32'd1);
    raw_a(1'b1, glyph(4'h5), 7'b1111111);
    err_a++;
    chk("inv_err", 32'(if_a.err), 32'd1);
    chk("inv_locked", 32'(if_a.locked), 32'd0);
    chk("inv_value", 32'(if_a.value), 32'h55);
    chk("inv_err_count", 32'(if_a.err_count), 32'(exp_errcnt(err_a)));
    strobe_a(8'h55);
    chk("inv_err_one_cycle", 32'(if_a.err), 32'd0);
    chk("inv_relock_restarts", 32'(if_a.locked), 32'd0);
    raw_a(1'b0, 7'b1111111, 7'b1111111);
    raw_a(1'b0, 7'b1111111, 7'b1111111);
    chk("gated_inv_err", 32'(if_a.err), 32'd0);
    chk("gated_inv_err_count", 32'(if_a.err_count), 32'(exp_errcnt(err_a)));

    // Gaps between matching strobes still lock after 4 strobes.
    strobe_a(8'h9E); idle_a(2);
    strobe_a(8'h9E); idle_a(3);
    strobe_a(8'h9E); idle_a(1);
    chk("gap_not_yet", 32'(if_a.locked), 32'd0);
    q_a.push_back(8'h9E);
    strobe_a(8'h9E);
    chk("gap_locked", 32'(if_a.locked), 32'd1);
    chk("gap_value", 32'(if_a.value), 32'h9E);

    // Invalid strobe in the completing slot: error, no lock.
    for (int i = 0; i < 3; i++) strobe_a(8'h31);
    raw_a(1'b1, 7'b1111110, glyph(4'h1));
    err_a++;
    chk("late_inv_err", 32'(if_a.err), 32'd1);
    chk("late_inv_locked", 32'(if_a.locked), 32'd0);
    chk("late_inv_value", 32'(if_a.value), 32'h9E);
    strobe_a(8'h31);
    chk("late_inv_recount", 32'(if_a.locked), 32'd0);

    // Reset mid-count, then four fresh strobes are needed.
    strobe_a(8'h77);
    strobe_a(8'h77);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_a("midcnt_rst");
    err_a = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) q_a.push_back(8'h77);
      strobe_a(8'h77);
      chk("post_rst_locked", 32'(if_a.locked), 32'(i == 3));
    end
    chk("post_rst_pulse", 32'(if_a.new_valid), 32'd1);
    // Reset while new_valid is high clears it at once.
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_a("midpulse_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Saturation of the error counter.
    for (int i = 0; i < 300; i++) begin
      raw_a(1'b1, 7'b1111111, 7'b1111111);
      err_a++;
    end
    chk("sat_err", 32'(if_a.err), 32'd1);
    chk("sat_err_count", 32'(if_a.err_count), 32'(exp_errcnt(err_a)));
    idle_a(1);
    chk("sat_err_drop", 32'(if_a.err), 32'd0);
    chk("sat_err_count_hold", 32'(if_a.err_count), 32'(exp_errcnt(err_a)));
    chk("a_final_drained", 32'(q_a.size()), 32'd0);

    // STABLE_CNT=1 sweep over all 256 valid digit pairs.
    for (int i = 0; i < 256; i++) begin
      logic [7:0] v;
      v = 8'(i);
      q_b.push_back(v);
      raw_b(1'b1, glyph(v[7:4]), glyph(v[3:0]));
      chk("sweep_pulse", 32'(if_b.new_valid), 32'd1);
    end
    chk("sweep_drained", 32'(q_b.size()), 32'd0);

    // 6 vs b discrimination.
    q_b.push_back(8'h6B);
    raw_b(1'b1, 7'b0100000, 7'b1100000);
    chk("6b_value", 32'(if_b.value), 32'h6B);
    raw_b(1'b1, 7'b0100000, 7'b1100000);
    chk("6b_same_no_pulse", 32'(if_b.new_valid), 32'd0);
    chk("6b_same_locked", 32'(if_b.locked), 32'd1);
    q_b.push_back(8'hB6);
    raw_b(1'b1, 7'b1100000, 7'b0100000);
    chk("b6_value", 32'(if_b.value), 32'hB6);
    raw_b(1'b0, 7'b1100000, 7'b0100000);
    chk("b_final_drained", 32'(q_b.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
